// File: rtl/image_pkg.sv
// Shared BMP constants, FSM state type and a little-endian byte helper
// for the image_write frame sink.
package image_pkg;

    localparam int unsigned BMP_HEADER_BYTES = 54;
    localparam int unsigned BMP_INFO_BYTES   = 40;
    localparam int unsigned BMP_BPP          = 24;

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StHeader,
        StPixels
    } state_e;

    function automatic logic [7:0] le_byte(logic [31:0] value, logic [1:0] k);
        return value[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/image_write_if.sv
// Pixel-pair input bus and byte-stream output port of the BMP frame sink.
interface image_write_if;

    logic       VSYNC;
    logic       HSYNC;
    logic [7:0] DATA_R0;
    logic [7:0] DATA_G0;
    logic [7:0] DATA_B0;
    logic [7:0] DATA_R1;
    logic [7:0] DATA_G1;
    logic [7:0] DATA_B1;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, out_ready,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, out_ready,
        output out_data, out_valid, out_last
    );

endinterface

// File: rtl/bmp_header_rom.sv
// Combinational 54-byte BMP file + info header for a 24-bit WIDTH x HEIGHT image.
module bmp_header_rom
    import image_pkg::*;
#(
    parameter int unsigned WIDTH  = 768,
    parameter int unsigned HEIGHT = 512
) (
    input  logic [5:0] idx,
    output logic [7:0] data
);

    localparam logic [31:0] IMAGE_SIZE = 32'(WIDTH * HEIGHT * 3);
    localparam logic [31:0] FILE_SIZE  = 32'(BMP_HEADER_BYTES) + IMAGE_SIZE;

    logic [31:0] field;
    logic [5:0]  base;

    always_comb begin
        field = '0;
        base  = '0;
        if (idx inside {[6'd2:6'd5]}) begin
            field = FILE_SIZE;
            base  = 6'd2;
        end else if (idx inside {[6'd10:6'd13]}) begin
            field = 32'(BMP_HEADER_BYTES);
            base  = 6'd10;
        end else if (idx inside {[6'd14:6'd17]}) begin
            field = 32'(BMP_INFO_BYTES);
            base  = 6'd14;
        end else if (idx inside {[6'd18:6'd21]}) begin
            field = 32'(WIDTH);
            base  = 6'd18;
        end else if (idx inside {[6'd22:6'd25]}) begin
            field = 32'(HEIGHT);
            base  = 6'd22;
        end else if (idx inside {[6'd26:6'd27]}) begin
            field = 32'd1;
            base  = 6'd26;
        end else if (idx inside {[6'd28:6'd29]}) begin
            field = 32'(BMP_BPP);
            base  = 6'd28;
        end else if (idx inside {[6'd34:6'd37]}) begin
            field = IMAGE_SIZE;
            base  = 6'd34;
        end

        data = le_byte(field, 2'(idx - base));
        if (idx == 6'd0) begin
            data = 8'h42;
        end else if (idx == 6'd1) begin
            data = 8'h4D;
        end
    end

endmodule

// File: rtl/image_write.sv
// Frame sink: captures a sync-qualified RGB888 pixel-pair frame bottom-up into a
// frame buffer, then streams it out as a complete 24-bit BMP file.
module image_write
    import image_pkg::*;
#(
    parameter int unsigned WIDTH  = 768,
    parameter int unsigned HEIGHT = 512
) (
    input  logic          HCLK,
    input  logic          HRESET,
    image_write_if.slave  bus,
    output logic          frame_done,
    output logic          drop_err
);

    localparam int unsigned PAIRS = WIDTH / 2;
    localparam int unsigned WORDS = WIDTH * HEIGHT / 2;
    localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    localparam logic [AW-1:0] LAST_WORD = AW'(WORDS - 1);
    localparam logic [RW-1:0] LAST_ROW  = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(PAIRS - 1);
    localparam logic [5:0]    HDR_END   = 6'(BMP_HEADER_BYTES);

    state_e          state_q;
    logic [RW-1:0]   row_q;
    logic [CW-1:0]   col_q;        // pair column, i.e. pixel column / 2
    logic [5:0]      hdr_idx_q;    // next header byte to load into the output register
    logic [AW-1:0]   rd_ptr_q;     // buffer word currently held in ram_rdata
    logic            last_word_q;
    logic [47:0]     word_q;
    logic [2:0]      byte_sel_q;
    logic [7:0]      out_data_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            frame_done_q;
    logic            drop_err_q;

    logic [47:0]     mem [WORDS];
    logic [47:0]     ram_rdata;

    logic [7:0]      hdr_byte;
    logic            xfer;
    logic            consume;
    logic            wr_en;
    logic            rd_en;
    logic [AW-1:0]   wr_addr;
    logic [AW-1:0]   rd_addr;
    logic [AW-1:0]   ram_addr;
    logic [47:0]     wr_data;

    bmp_header_rom #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_hdr_rom (
        .idx  (hdr_idx_q),
        .data (hdr_byte)
    );

    // consume: the byte now transferring is the last of the header or of a word,
    // so the prefetched word moves into word_q and the following word is read.
    always_comb begin
        xfer    = out_valid_q && bus.out_ready;
        consume = xfer && ((state_q == StHeader && hdr_idx_q == HDR_END) ||
                           (state_q == StPixels && !out_last_q && byte_sel_q == 3'd6));
        wr_en   = (state_q == StCapture) && !bus.VSYNC && bus.HSYNC;
        wr_addr = AW'((HEIGHT - 1 - 32'(row_q)) * PAIRS + 32'(col_q));
        wr_data = {bus.DATA_R1, bus.DATA_G1, bus.DATA_B1, bus.DATA_R0, bus.DATA_G0, bus.DATA_B0};
        rd_en   = (state_q == StHeader) || (consume && rd_ptr_q != LAST_WORD);
        rd_addr = consume ? rd_ptr_q + 1'b1 : rd_ptr_q;
        ram_addr = wr_en ? wr_addr : rd_addr;
    end

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem[ram_addr] <= wr_data;
        end else if (rd_en) begin
            ram_rdata <= mem[ram_addr];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= StIdle;
            row_q        <= '0;
            col_q        <= '0;
            hdr_idx_q    <= '0;
            rd_ptr_q     <= '0;
            last_word_q  <= 1'b0;
            word_q       <= '0;
            byte_sel_q   <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (bus.HSYNC && (state_q == StHeader || state_q == StPixels)) begin
                drop_err_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (bus.VSYNC) begin
                        state_q <= StCapture;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end

                StCapture: begin
                    if (bus.VSYNC) begin
                        row_q <= '0;
                        col_q <= '0;
                    end else if (bus.HSYNC) begin
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            if (row_q == LAST_ROW) begin
                                // hdr_idx_q is 0 here, so hdr_byte is the first header byte
                                state_q     <= StHeader;
                                row_q       <= '0;
                                out_valid_q <= 1'b1;
                                out_data_q  <= hdr_byte;
                                out_last_q  <= 1'b0;
                                hdr_idx_q   <= 6'd1;
                                rd_ptr_q    <= '0;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end

                StHeader, StPixels: begin
                    if (consume) begin
                        state_q     <= StPixels;
                        word_q      <= ram_rdata;
                        out_data_q  <= ram_rdata[7:0];
                        out_last_q  <= 1'b0;
                        byte_sel_q  <= 3'd1;
                        last_word_q <= (rd_ptr_q == LAST_WORD);
                        if (rd_ptr_q != LAST_WORD) begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end else if (xfer) begin
                        if (state_q == StHeader) begin
                            out_data_q <= hdr_byte;
                            hdr_idx_q  <= hdr_idx_q + 6'd1;
                        end else if (out_last_q) begin
                            state_q      <= StIdle;
                            out_valid_q  <= 1'b0;
                            out_last_q   <= 1'b0;
                            out_data_q   <= '0;
                            frame_done_q <= 1'b1;
                            hdr_idx_q    <= '0;
                            last_word_q  <= 1'b0;
                        end else begin
                            out_data_q <= word_q[{byte_sel_q, 3'b000} +: 8];
                            out_last_q <= last_word_q && byte_sel_q == 3'd5;
                            byte_sel_q <= byte_sel_q + 3'd1;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign frame_done    = frame_done_q;
    assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_image_write.sv
// Directed bench for image_write on a 4x2 frame plus a default-size header ROM.
module tb_image_write;

    localparam int W           = 4;
    localparam int H           = 2;
    localparam int FRAME_BYTES = 54 + W * H * 3;

    logic       HCLK   = 1'b0;
    logic       HRESET = 1'b1;
    logic       frame_done;
    logic       drop_err;
    logic [5:0] rom_idx;
    logic [7:0] rom_byte;

    int n_checks = 0;
    int n_errors = 0;

    image_write_if bus ();

    image_write #(
        .WIDTH  (W),
        .HEIGHT (H)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .bus        (bus),
        .frame_done (frame_done),
        .drop_err   (drop_err)
    );

    bmp_header_rom #(
        .WIDTH  (768),
        .HEIGHT (512)
    ) u_rom_dflt (
        .idx  (rom_idx),
        .data (rom_byte)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // ch: 0=R, 1=G, 2=B; pixel (0,0) of seed 0 is R=10 G=20 B=30
    function automatic logic [7:0] px(int seed, int r, int c, int ch);
        return 8'((ch + 1) * 16 + r * 64 + c * 4 + seed);
    endfunction

    function automatic logic [7:0] hdr_exp(int i);
        case (i)
            0:       return 8'h42;
            1:       return 8'h4D;
            2:       return 8'h4E;
            10:      return 8'h36;
            14:      return 8'h28;
            18:      return 8'h04;
            22:      return 8'h02;
            26:      return 8'h01;
            28:      return 8'h18;
            34:      return 8'h18;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_byte(int seed, int i);
        int k, w, b, r, c;
        if (i < 54) return hdr_exp(i);
        k = i - 54;
        w = k / 6;
        b = k % 6;
        r = H - 1 - w / (W / 2);
        c = 2 * (w % (W / 2)) + b / 3;
        return px(seed, r, c, 2 - b % 3);
    endfunction

    task automatic start_frame();
        bus.VSYNC = 1'b1;
        @(posedge HCLK);
        #1;
        bus.VSYNC = 1'b0;
    endtask

    task automatic send_pairs(input int seed, input int n);
        for (int i = 0; i < n; i++) begin
            int r, c;
            r = i / (W / 2);
            c = 2 * (i % (W / 2));
            bus.DATA_R0 = px(seed, r, c, 0);
            bus.DATA_G0 = px(seed, r, c, 1);
            bus.DATA_B0 = px(seed, r, c, 2);
            bus.DATA_R1 = px(seed, r, c + 1, 0);
            bus.DATA_G1 = px(seed, r, c + 1, 1);
            bus.DATA_B1 = px(seed, r, c + 1, 2);
            bus.HSYNC   = 1'b1;
            @(posedge HCLK);
            #1;
        end
        bus.HSYNC = 1'b0;
    endtask

    task automatic check_start();
        check("start_valid", bus.out_valid, 1'b1);
        check("start_data", bus.out_data, 8'h42);
    endtask

    task automatic collect(input int seed, input bit rand_ready, input int stop_at,
                           input bit inject);
        int         idx = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held_data = '0;
        logic       held_last = 1'b0;
        while (idx < stop_at && cyc < 1000) begin
            if (stalled) begin
                check("hold_data", bus.out_data, held_data);
                check("hold_last", bus.out_last, held_last);
            end
            check("valid_high", bus.out_valid, 1'b1);
            check("done_low", frame_done, 1'b0);
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.HSYNC     = inject && cyc < 3;
            bus.DATA_R0   = 8'hEE;
            if (bus.out_ready) begin
                check($sformatf("byte%0d", idx), bus.out_data, exp_byte(seed, idx));
                check($sformatf("last%0d", idx), bus.out_last, idx == FRAME_BYTES - 1);
                idx++;
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_data = bus.out_data;
                held_last = bus.out_last;
            end
            @(posedge HCLK);
            #1;
            cyc++;
        end
        bus.HSYNC     = 1'b0;
        bus.out_ready = 1'b1;
        if (idx < stop_at) check("stream_timeout", idx, stop_at);
    endtask

    task automatic finish_frame(input bit chain);
        check("done_pulse", frame_done, 1'b1);
        check("done_valid_low", bus.out_valid, 1'b0);
        bus.VSYNC = chain;
        @(posedge HCLK);
        #1;
        bus.VSYNC = 1'b0;
        check("done_one_cycle", frame_done, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         ridx [8] = '{2, 3, 4, 5, 18, 19, 22, 23};
        logic [7:0] rexp [8] = '{8'h36, 8'h00, 8'h12, 8'h00, 8'h00, 8'h03, 8'h00, 8'h02};

        bus.VSYNC     = 1'b0;
        bus.HSYNC     = 1'b0;
        bus.DATA_R0   = '0;
        bus.DATA_G0   = '0;
        bus.DATA_B0   = '0;
        bus.DATA_R1   = '0;
        bus.DATA_G1   = '0;
        bus.DATA_B1   = '0;
        bus.out_ready = 1'b1;
        rom_idx       = '0;

        repeat (2) @(posedge HCLK);
        #1;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_data", bus.out_data, 8'h00);
        check("rst_last", bus.out_last, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_drop", drop_err, 1'b0);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        // Basic frame, then a VSYNC in the frame_done cycle chains the next frame
        start_frame();
        send_pairs(0, W * H / 2);
        check_start();
        collect(0, 1'b0, FRAME_BYTES, 1'b0);
        finish_frame(1'b1);

        // Same frame under random backpressure
        send_pairs(0, W * H / 2);
        check_start();
        collect(0, 1'b1, FRAME_BYTES, 1'b0);
        finish_frame(1'b0);
        check("drop_err_clean", drop_err, 1'b0);

        // Restart after 3 pairs; only the new frame must come out
        start_frame();
        send_pairs(5, 3);
        check("partial_no_stream", bus.out_valid, 1'b0);
        start_frame();
        send_pairs(2, W * H / 2);
        check_start();
        collect(2, 1'b0, FRAME_BYTES, 1'b0);
        finish_frame(1'b0);

        // HSYNC during the header
        start_frame();
        send_pairs(3, W * H / 2);
        check_start();
        collect(3, 1'b1, FRAME_BYTES, 1'b1);
        finish_frame(1'b0);
        check("drop_err_set", drop_err, 1'b1);

        // Reset at byte 60
        start_frame();
        send_pairs(4, W * H / 2);
        collect(4, 1'b0, 60, 1'b0);
        check("drop_err_sticky", drop_err, 1'b1);
        #2;
        HRESET = 1'b1;
        #1;
        check("async_rst_valid", bus.out_valid, 1'b0);
        check("async_rst_data", bus.out_data, 8'h00);
        check("async_rst_last", bus.out_last, 1'b0);
        check("async_rst_drop", drop_err, 1'b0);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge HCLK);
            #1;
            check("post_rst_done", frame_done, 1'b0);
            check("post_rst_valid", bus.out_valid, 1'b0);
        end
        start_frame();
        send_pairs(6, W * H / 2);
        check_start();
        collect(6, 1'b0, FRAME_BYTES, 1'b0);
        finish_frame(1'b0);

        // 768x512 header fields
        for (int i = 0; i < 8; i++) begin
            rom_idx = 6'(ridx[i]);
            #1;
            check($sformatf("dflt_hdr%0d", ridx[i]), rom_byte, rexp[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
